// File: rtl/uart_pkg.sv
// Shared UART constants and baud-rate derivation.
// The transmitter and the receiver both use this package.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Kept at least one bit wide so that a degenerate one-cycle symbol still elaborates.
  function automatic int clock_counter_width(input int edge_time);
    return (edge_time > 1) ? $clog2(edge_time) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running symbol timer: emits a single-cycle tick every SYMBOL_EDGE_TIME cycles.
// While clear is high the count is held at zero.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int SYMBOL_EDGE_TIME = 1085
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CLOCK_COUNTER_WIDTH = clock_counter_width(SYMBOL_EDGE_TIME);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] LAST_COUNT =
    CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);

  logic [CLOCK_COUNTER_WIDTH-1:0] count;

  assign tick = ~clear & (count == LAST_COUNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter. It accepts one byte per ready/valid handshake
// and shifts the frame out LSB first on serial_out.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [UART_DATA_BITS-1:0] data_in,
  input  logic                      data_in_valid,
  output logic                      data_in_ready,
  output logic                      serial_out
);

  localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam logic [3:0] LAST_DATA_BIT = 4'(UART_DATA_BITS);
  localparam logic [3:0] LAST_BIT      = 4'(UART_FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                     state, state_next;
  logic [UART_FRAME_BITS-1:0] shift_reg;
  logic [3:0]                 bit_count;
  logic                       tick, fire, load, advance;

  assign data_in_ready = (state == IDLE) & ~rst;
  assign fire          = data_in_valid & data_in_ready;
  // The shift register resets to all ones, so the line idles at mark without extra muxing.
  assign serial_out    = shift_reg[0];

  uart_baud_tick #(
    .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)
  ) baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(state == IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (fire) begin
          load       = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (tick) begin
          advance    = 1'b1;
          state_next = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          advance = 1'b1;
          if (bit_count == LAST_DATA_BIT) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          advance    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Ones shift in from the top, so the stop bit and the following idle time need no special case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '1;
      bit_count <= '0;
    end else if (load) begin
      shift_reg <= {1'b1, data_in, 1'b0};
      bit_count <= '0;
    end else if (advance) begin
      shift_reg <= {1'b1, shift_reg[UART_FRAME_BITS-1:1]};
      bit_count <= (bit_count == LAST_BIT) ? 4'd0 : bit_count + 4'd1;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter. Each frame is checked cycle by cycle against
// hand-computed bit patterns, and a small serial receiver model decodes the line.
module tb_uart_transmitter;

  // 1_250_000 / 115_200 truncates to 10 clocks per bit.
  localparam int CLOCK_FREQ = 1_250_000;
  localparam int BAUD_RATE  = 115_200;
  localparam int BIT        = 10;
  localparam int FRAME      = 10 * BIT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       serial_out;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  logic       mon_enable = 1'b0;
  logic [7:0] mon_bytes[$];
  logic       mon_stops[$];
  int         mon_starts[$];

  uart_transmitter #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Receiver model: it finds the start-bit edge and then samples each bit in the middle of its period.
  initial begin : receiver_model
    logic [7:0] rx;
    logic       stop_bit;
    int         t0;
    forever begin
      @(posedge clk); #1;
      if (mon_enable && serial_out === 1'b0) begin
        t0 = cycle;
        repeat (BIT / 2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(posedge clk); #1;
          rx[i] = serial_out;
        end
        repeat (BIT) @(posedge clk); #1;
        stop_bit = serial_out;
        mon_starts.push_back(t0);
        mon_bytes.push_back(rx);
        mon_stops.push_back(stop_bit);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic waitReady(input string tag);
    int n;
    n = 0;
    while (data_in_ready !== 1'b1 && n < 20 * BIT) begin
      @(posedge clk); #1;
      n++;
    end
    if (data_in_ready !== 1'b1) checkOutput({tag, "_ready_timeout"}, 0, 1);
  endtask

  // Sends one byte. Each bit must hold its expected level for exactly BIT cycles,
  // and ready must stay low for the whole frame.
  task automatic applyStimulus(input string tag, input logic [7:0] value,
                               input logic [9:0] frame_exp, input bit disturb);
    int held[10];
    int ready_low;
    for (int k = 0; k < 10; k++) held[k] = 0;
    ready_low = 0;
    waitReady(tag);
    data_in       = value;
    data_in_valid = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    for (int c = 0; c < FRAME; c++) begin
      if (serial_out === frame_exp[c / BIT]) held[c / BIT]++;
      if (data_in_ready === 1'b0) ready_low++;
      if (disturb) begin
        data_in       = 8'hFF;
        data_in_valid = c[0];
      end
      @(posedge clk); #1;
    end
    data_in_valid = 1'b0;
    for (int k = 0; k < 10; k++) checkOutput($sformatf("%s_bit%0d_cycles", tag, k), held[k], BIT);
    checkOutput({tag, "_ready_low_cycles"}, ready_low, FRAME);
    checkOutput({tag, "_ready_after_frame"}, data_in_ready, 1);
    checkOutput({tag, "_line_after_frame"}, serial_out, 1);
  endtask

  initial begin : main
    // Reset held for 10 clocks
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("reset_line_%0d", i), serial_out, 1);
      checkOutput($sformatf("reset_ready_%0d", i), data_in_ready, 0);
    end
    rst = 1'b0;
    #1;
    checkOutput("ready_on_release", data_in_ready, 1);
    @(posedge clk); #1;
    checkOutput("ready_first_clk", data_in_ready, 1);
    checkOutput("line_first_clk", serial_out, 1);

    // Single byte 'a'
    applyStimulus("a61", 8'h61, 10'b1011000010, 1'b0);

    // Back-to-back 'a'..'j' with valid held high
    mon_bytes.delete(); mon_stops.delete(); mon_starts.delete();
    mon_enable    = 1'b1;
    data_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = 8'h61 + 8'(i);
      waitReady($sformatf("b2b_%0d", i));
      @(posedge clk); #1;
    end
    data_in_valid = 1'b0;
    repeat (FRAME + 10) @(posedge clk); #1;
    mon_enable = 1'b0;
    checkOutput("b2b_count", mon_bytes.size(), 10);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("b2b_byte_%0d", i),
                  (i < mon_bytes.size()) ? int'(mon_bytes[i]) : -1, 8'h61 + i);
      checkOutput($sformatf("b2b_stop_%0d", i),
                  (i < mon_stops.size()) ? int'(mon_stops[i]) : -1, 1);
    end
    for (int i = 1; i < 10; i++) begin
      checkOutput($sformatf("b2b_spacing_%0d", i),
                  (i < mon_starts.size()) ? mon_starts[i] - mon_starts[i-1] : -1, FRAME + 1);
    end

    // Input disturbance during a frame of 8'h00
    applyStimulus("stable00", 8'h00, 10'b1000000000, 1'b1);
    repeat (2 * BIT) @(posedge clk); #1;
    checkOutput("stable_no_extra_frame_line", serial_out, 1);
    checkOutput("stable_no_extra_frame_ready", data_in_ready, 1);

    // Asynchronous reset during data bit 3 of 8'h55
    waitReady("rst55");
    data_in       = 8'h55;
    data_in_valid = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    repeat (4 * BIT + 3) @(posedge clk); #1;
    checkOutput("rst55_line_before", serial_out, 0);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rst55_line_immediate", serial_out, 1);
    checkOutput("rst55_ready_in_reset", data_in_ready, 0);
    repeat (3) @(posedge clk);
    #4;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst55_ready_after", data_in_ready, 1);
    checkOutput("rst55_line_after", serial_out, 1);
    repeat (2 * BIT) @(posedge clk); #1;
    checkOutput("rst55_no_resume", serial_out, 1);
    applyStimulus("a5", 8'hA5, 10'b1101001010, 1'b0);

    // Edge values, also decoded by the receiver model
    mon_bytes.delete(); mon_stops.delete(); mon_starts.delete();
    mon_enable = 1'b1;
    applyStimulus("edge00", 8'h00, 10'b1000000000, 1'b0);
    applyStimulus("edgeFF", 8'hFF, 10'b1111111110, 1'b0);
    repeat (BIT) @(posedge clk); #1;
    mon_enable = 1'b0;
    checkOutput("edge_count", mon_bytes.size(), 2);
    checkOutput("edge_rx_00", (mon_bytes.size() > 0) ? int'(mon_bytes[0]) : -1, 8'h00);
    checkOutput("edge_rx_FF", (mon_bytes.size() > 1) ? int'(mon_bytes[1]) : -1, 8'hFF);
    checkOutput("edge_stop_00", (mon_stops.size() > 0) ? int'(mon_stops[0]) : -1, 1);
    checkOutput("edge_stop_FF", (mon_stops.size() > 1) ? int'(mon_stops[1]) : -1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
